line_buffer_sched: RTL and testbench
====================================

# line_buffer_sched

Scheduler for the four 512-pixel line buffers feeding the 3x3 convolution datapath inside the image-processing IP. It steers incoming pixels into one line buffer at a time and starts reading once three lines are buffered. Reads draw from three buffers in rotation under downstream backpressure. It raises an interrupt each time a line buffer is freed, so the host DMA can push the next image row.

## Interface
- LINE_WIDTH, 512, pixels per image line (power of two, ≥8)
- FILL_W, $clog2(4*LINE_WIDTH+1), width of the internal fill counter (derived, not overridden)

- axi_clk  in  1  clock, all logic on rising edge
- axi_rst  in  1  reset, synchronous, active-high
- i_pixel_valid  in  1  pixel present on the line-buffer write bus this cycle
- o_in_ready  out  1  scheduler can accept a pixel; a write happens only when i_pixel_valid && o_in_ready
- o_wr_en  out  4  one-hot write enable to line buffers 0..3
- i_out_ready  in  1  downstream convolution stage can accept a window
- o_rd_en  out  4  read enables, three bits set during a read cycle
- o_rd_sel  out  2  index of the buffer holding the top row of the window (rd_ptr)
- o_window_valid  out  1  3x3 window data valid at line-buffer outputs
- o_intr  out  1  one-cycle pulse: one line buffer freed

## Operation
- Write side:
  - wr_ptr (2 b) and wr_col (0..LINE_WIDTH-1) advance on each accepted write.
  - o_wr_en = accepted ? (1 << wr_ptr) : 0.
  - wr_col wraps LINE_WIDTH-1 -> 0, and wr_ptr increments mod 4 on that wrap.
- Fill counter:
  - fill += accepted write; fill -= read cycle.
  - Simultaneous write and read: fill unchanged.
  - Range 0..4*LINE_WIDTH.
  - o_in_ready = (fill < 4*LINE_WIDTH).
  - Writes with o_in_ready low are dropped: no o_wr_en, no counter change.
- FSM, states IDLE and READ:
  - IDLE -> READ when fill ≥ 3*LINE_WIDTH (registered compare, evaluated every cycle).
  - READ:
    - read cycle = i_out_ready.
    - o_rd_en = bits rd_ptr, rd_ptr+1, rd_ptr+2 (mod 4) set when i_out_ready, else 0.
    - rd_col increments per read cycle.
  - On the read cycle with rd_col == LINE_WIDTH-1: rd_col -> 0, rd_ptr increments mod 4, state -> IDLE, o_intr pulses.
- o_rd_sel = rd_ptr, combinational from register.
- Wrap example: rd_ptr=2 gives o_rd_en = 4'b1101; rd_ptr=3 gives 4'b1011.
- No border padding; edge rows/columns are the downstream stage's concern.

## Timing
- Reset values:
  - o_wr_en=0, o_rd_en=0, o_rd_sel=0, o_window_valid=0, o_intr=0, o_in_ready=1.
  - Internal: fill=0, state IDLE, all pointers/columns 0.
- o_wr_en is combinational from i_pixel_valid and registered wr_ptr, so it asserts in the same cycle as the accepted write.
- o_rd_en is combinational from state, rd_ptr and i_out_ready.
- o_window_valid = o_rd_en != 0, registered one cycle later, matching the 1-cycle line-buffer read latency.
- o_intr is registered and asserts the cycle after the last read cycle of a line, for exactly one cycle.
- READ entry: the 3*LINE_WIDTH-th write in cycle N -> state READ in cycle N+2 (fill update N+1, compare N+2).
- Back-to-back lines: after READ -> IDLE, re-entry to READ is at the earliest two cycles later if fill still ≥ 3*LINE_WIDTH.
- Reset asserted mid-operation: all state returns to reset values at the next edge. In-flight o_window_valid and o_intr are cleared.

## Configuration
- LBS_STATUS_EN defined:
  - Adds output o_fill (FILL_W) mirroring the fill counter.
  - Adds output o_overflow (1), a sticky flag set when i_pixel_valid && !o_in_ready, cleared only by axi_rst.
- LBS_STATUS_EN undefined: neither port exists and no drop detection logic is built. Behaviour is otherwise identical.

## Structure
- Package lbs_pkg holds:
  - the state enum (LBS_IDLE, LBS_READ);
  - constant NUM_LB=4;
  - the function rd_mask(ptr) returning the 3-of-4 one-hot read mask.
- One sub-module, lbs_wrap_cnt: parameterised modulo counter with enable, synchronous clear and wrap pulse. It is instantiated for wr_col and rd_col; the 2-bit pointers are plain increments.

## Test plan
- Reset: hold axi_rst 3 cycles -> all outputs 0 except o_in_ready=1, then 10 idle cycles with no change.
- Fill 3 lines: 1536 consecutive valid pixels -> o_wr_en 0001 (512 cycles), 0010 (512), 0100 (512); o_rd_en=0111 two cycles after the last write with i_out_ready=1.
- Line read: i_out_ready held 1 -> exactly 512 read cycles, o_window_valid lagging 1 cycle, o_intr a single pulse after the 512th, o_rd_sel becomes 1, next READ uses 1110.
- Backpressure: drop i_out_ready for 10 cycles at rd_col=100 -> o_rd_en=0 and rd_col holds at 100, o_window_valid low one cycle later, resumes at 100.
- Full/overflow: 2049 writes with i_out_ready=0 -> o_in_ready falls after the 2048th, 2049th produces no o_wr_en; with LBS_STATUS_EN, o_fill=2048 and o_overflow=1.
- Rotation wrap plus mid-read reset: stream 6 lines -> o_rd_en sequence 0111, 1110, 1101; assert axi_rst at rd_col=200 -> next cycle state IDLE, o_rd_sel=0, o_in_ready=1.

Source files
------------

// File: rtl/lbs_pkg.sv
// rtl/lbs_pkg.sv - shared state type, buffer count and read-mask helper for line_buffer_sched
package lbs_pkg;

    typedef enum logic {
        LBS_IDLE = 1'b0,
        LBS_READ = 1'b1
    } lbs_state_e;

    localparam int NUM_LB = 4;

    // Three consecutive buffers starting at ptr, wrapping modulo four.
    function automatic logic [NUM_LB-1:0] rd_mask(input logic [1:0] ptr);
        logic [2*NUM_LB-1:0] m;
        m = 8'b0000_0111 << ptr;
        return m[NUM_LB-1:0] | m[2*NUM_LB-1:NUM_LB];
    endfunction

endpackage

// File: rtl/lbs_wrap_cnt.sv
// rtl/lbs_wrap_cnt.sv - modulo counter with enable, synchronous clear and wrap pulse
module lbs_wrap_cnt #(
    parameter int MODULUS = 512,
    parameter int W       = $clog2(MODULUS)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic wrap_o
);
    localparam logic [W-1:0] LAST = W'(MODULUS - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign wrap_o = en_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || wrap_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/line_buffer_sched.sv
// rtl/line_buffer_sched.sv - four-line-buffer write steering and 3-row read scheduler; LBS_STATUS_EN adds o_fill/o_overflow
module line_buffer_sched
    import lbs_pkg::*;
#(
    parameter  int LINE_WIDTH = 512,
    localparam int FILL_W     = $clog2(4*LINE_WIDTH+1)
) (
    input  logic              axi_clk,
    input  logic              axi_rst,
    input  logic              i_pixel_valid,
    output logic              o_in_ready,
    output logic [NUM_LB-1:0] o_wr_en,
    input  logic              i_out_ready,
    output logic [NUM_LB-1:0] o_rd_en,
    output logic [1:0]        o_rd_sel,
    output logic              o_window_valid,
    output logic              o_intr
`ifdef LBS_STATUS_EN
    ,
    output logic [FILL_W-1:0] o_fill,
    output logic              o_overflow
`endif
);
    localparam logic [FILL_W-1:0] FILL_FULL  = FILL_W'(4*LINE_WIDTH);
    localparam logic [FILL_W-1:0] FILL_START = FILL_W'(3*LINE_WIDTH);

    lbs_state_e        state_q;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [1:0]        wr_ptr_q, wr_ptr_d;
    logic [1:0]        rd_ptr_q, rd_ptr_d;
    logic              window_valid_q;
    logic              intr_q;
    logic              wr_acc, rd_cyc, wr_wrap, rd_wrap;

    assign o_in_ready     = fill_q < FILL_FULL;
    assign wr_acc         = i_pixel_valid && o_in_ready;
    assign rd_cyc         = (state_q == LBS_READ) && i_out_ready;
    assign o_wr_en        = wr_acc ? (4'b0001 << wr_ptr_q) : '0;
    assign o_rd_en        = rd_cyc ? rd_mask(rd_ptr_q) : '0;
    assign o_rd_sel       = rd_ptr_q;
    assign o_window_valid = window_valid_q;
    assign o_intr         = intr_q;

    lbs_wrap_cnt #(.MODULUS(LINE_WIDTH)) u_wr_col (
        .clk_i  (axi_clk),
        .rst_i  (axi_rst),
        .clr_i  (1'b0),
        .en_i   (wr_acc),
        .wrap_o (wr_wrap)
    );

    lbs_wrap_cnt #(.MODULUS(LINE_WIDTH)) u_rd_col (
        .clk_i  (axi_clk),
        .rst_i  (axi_rst),
        .clr_i  (1'b0),
        .en_i   (rd_cyc),
        .wrap_o (rd_wrap)
    );

    // A write and a read in the same cycle cancel out in the fill count.
    always_comb begin
        fill_d = fill_q;
        if (wr_acc && !rd_cyc) begin
            fill_d = fill_q + FILL_W'(1);
        end else if (!wr_acc && rd_cyc) begin
            fill_d = fill_q - FILL_W'(1);
        end
        wr_ptr_d = wr_wrap ? wr_ptr_q + 2'd1 : wr_ptr_q;
        rd_ptr_d = rd_wrap ? rd_ptr_q + 2'd1 : rd_ptr_q;
    end

    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            state_q        <= LBS_IDLE;
            fill_q         <= '0;
            wr_ptr_q       <= 2'd0;
            rd_ptr_q       <= 2'd0;
            window_valid_q <= 1'b0;
            intr_q         <= 1'b0;
        end else begin
            fill_q         <= fill_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            window_valid_q <= rd_cyc;
            intr_q         <= rd_wrap;
            case (state_q)
                LBS_IDLE: if (fill_q >= FILL_START) state_q <= LBS_READ;
                LBS_READ: if (rd_wrap) state_q <= LBS_IDLE;
            endcase
        end
    end

`ifdef LBS_STATUS_EN
    logic overflow_q;

    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            overflow_q <= 1'b0;
        end else if (i_pixel_valid && !o_in_ready) begin
            overflow_q <= 1'b1;
        end
    end

    assign o_fill     = fill_q;
    assign o_overflow = overflow_q;
`endif

endmodule

// File: tb/tb_line_buffer_sched.sv
// tb/tb_line_buffer_sched.sv - scoreboard bench for line_buffer_sched (LBS_STATUS_EN checks when defined)
module tb_line_buffer_sched;

    logic       axi_clk;
    logic       axi_rst;
    logic       i_pixel_valid;
    logic       o_in_ready;
    logic [3:0] o_wr_en;
    logic       i_out_ready;
    logic [3:0] o_rd_en;
    logic [1:0] o_rd_sel;
    logic       o_window_valid;
    logic       o_intr;
`ifdef LBS_STATUS_EN
    logic [11:0] o_fill;
    logic        o_overflow;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] wr_q[$];
    logic [3:0] rd_q[$];
    logic [1:0] intr_q[$];

    line_buffer_sched #(.LINE_WIDTH(512)) dut (
        .axi_clk        (axi_clk),
        .axi_rst        (axi_rst),
        .i_pixel_valid  (i_pixel_valid),
        .o_in_ready     (o_in_ready),
        .o_wr_en        (o_wr_en),
        .i_out_ready    (i_out_ready),
        .o_rd_en        (o_rd_en),
        .o_rd_sel       (o_rd_sel),
        .o_window_valid (o_window_valid),
        .o_intr         (o_intr)
`ifdef LBS_STATUS_EN
        ,
        .o_fill         (o_fill),
        .o_overflow     (o_overflow)
`endif
    );

    initial begin
        axi_clk = 1'b0;
        forever #5 axi_clk = ~axi_clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge axi_clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        axi_rst       = 1'b1;
        i_pixel_valid = 1'b0;
        i_out_ready   = 1'b0;
        repeat (n) step();
        axi_rst = 1'b0;
    endtask

    // Monitor: pops an expectation whenever the DUT presents a write, read or interrupt.
    always @(negedge axi_clk) begin
        if (o_wr_en != 4'b0) begin
            if (wr_q.size() == 0) chk("wr_unexpected", int'(o_wr_en), 0);
            else chk("sb_wr_en", int'(o_wr_en), int'(wr_q.pop_front()));
        end
        if (o_rd_en != 4'b0) begin
            if (rd_q.size() == 0) chk("rd_unexpected", int'(o_rd_en), 0);
            else chk("sb_rd_en", int'(o_rd_en), int'(rd_q.pop_front()));
        end
        if (o_intr) begin
            if (intr_q.size() == 0) chk("intr_unexpected", 1, 0);
            else chk("sb_intr_rd_sel", int'(o_rd_sel), int'(intr_q.pop_front()));
        end
    end

    initial begin
        axi_rst       = 1'b1;
        i_pixel_valid = 1'b0;
        i_out_ready   = 1'b0;
        repeat (3) step();
        @(negedge axi_clk);
        chk("reset_outs", int'({o_wr_en, o_rd_en, o_rd_sel, o_window_valid, o_intr, o_in_ready}), 1);
        step();
        axi_rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge axi_clk);
            chk("idle_outs", int'({o_wr_en, o_rd_en, o_rd_sel, o_window_valid, o_intr, o_in_ready}), 1);
            step();
        end

        // Fill three lines, read one, add a fourth, read with a 10-cycle stall at rd_col 100.
        repeat (512) rd_q.push_back(4'b0111);
        repeat (512) rd_q.push_back(4'b1110);
        intr_q.push_back(2'd1);
        intr_q.push_back(2'd2);
        for (int t = 0; t <= 3086; t++) begin
            i_pixel_valid = (t < 1536) || (t >= 2050 && t < 2562);
            i_out_ready   = !(t >= 2663 && t < 2673);
            if (i_pixel_valid) wr_q.push_back(t < 1536 ? 4'(1 << (t / 512)) : 4'b1000);
            @(negedge axi_clk);
            case (t)
                1536: chk("a_rd_en_pre", int'(o_rd_en), 0);
                1537: begin
                    chk("a_rd_en_first", int'(o_rd_en), 4'b0111);
                    chk("a_wv_lag0", int'(o_window_valid), 0);
                end
                1538: chk("a_wv_lag1", int'(o_window_valid), 1);
                2048: chk("a_intr_early", int'(o_intr), 0);
                2049: begin
                    chk("a_intr_pulse", int'(o_intr), 1);
                    chk("a_rd_sel1", int'(o_rd_sel), 1);
                    chk("a_rd_en_idle", int'(o_rd_en), 0);
                    chk("a_wv_last", int'(o_window_valid), 1);
                end
                2050: begin
                    chk("a_intr_one_cycle", int'(o_intr), 0);
                    chk("a_wv_off", int'(o_window_valid), 0);
                end
                2562: chk("a_rd_en_pre2", int'(o_rd_en), 0);
                2563: chk("a_rd_en_1110", int'(o_rd_en), 4'b1110);
                2663: begin
                    chk("a_stall_rd_en", int'(o_rd_en), 0);
                    chk("a_stall_wv_lag", int'(o_window_valid), 1);
                end
                2664: chk("a_stall_wv_off", int'(o_window_valid), 0);
                2672: chk("a_stall_end_rd_en", int'(o_rd_en), 0);
                2673: chk("a_resume_rd_en", int'(o_rd_en), 4'b1110);
                3084: chk("a_intr_before_resume_end", int'(o_intr), 0);
                3085: begin
                    chk("a_intr_after_stall", int'(o_intr), 1);
                    chk("a_rd_sel2", int'(o_rd_sel), 2);
                end
                default: ;
            endcase
            step();
        end

        // Fill to capacity with no downstream reads, then one dropped write.
        do_reset(2);
        for (int t = 0; t <= 2049; t++) begin
            i_pixel_valid = (t <= 2048);
            i_out_ready   = 1'b0;
            if (t < 2048) wr_q.push_back(4'(1 << (t / 512)));
            @(negedge axi_clk);
            case (t)
                2047: begin
                    chk("b_in_ready_before_full", int'(o_in_ready), 1);
`ifdef LBS_STATUS_EN
                    chk("b_overflow_clear", int'(o_overflow), 0);
`endif
                end
                2048: begin
                    chk("b_in_ready_full", int'(o_in_ready), 0);
                    chk("b_dropped_wr_en", int'(o_wr_en), 0);
                end
`ifdef LBS_STATUS_EN
                2049: begin
                    chk("b_fill", int'(o_fill), 2048);
                    chk("b_overflow_set", int'(o_overflow), 1);
                end
`endif
                default: ;
            endcase
            step();
        end

        // Continuous stream: rotation 0111, 1110, 1101, reset at rd_col 200 of the third line.
        do_reset(2);
        repeat (512) rd_q.push_back(4'b0111);
        repeat (512) rd_q.push_back(4'b1110);
        repeat (201) rd_q.push_back(4'b1101);
        intr_q.push_back(2'd1);
        intr_q.push_back(2'd2);
        for (int t = 0; t <= 2764; t++) begin
            i_pixel_valid = (t < 2763);
            i_out_ready   = 1'b1;
            axi_rst       = (t == 2763);
            if (i_pixel_valid) wr_q.push_back(4'(1 << ((t / 512) % 4)));
            @(negedge axi_clk);
            case (t)
                1536: chk("c_rd_en_pre", int'(o_rd_en), 0);
                1537: chk("c_rd_en_0111", int'(o_rd_en), 4'b0111);
                2049: begin
                    chk("c_gap1_rd_en", int'(o_rd_en), 0);
                    chk("c_gap1_intr", int'(o_intr), 1);
                end
                2050: chk("c_rd_en_1110", int'(o_rd_en), 4'b1110);
                2562: chk("c_gap2_rd_en", int'(o_rd_en), 0);
                2563: chk("c_rd_en_1101", int'(o_rd_en), 4'b1101);
                2763: chk("c_rd_en_at_reset", int'(o_rd_en), 4'b1101);
                2764: begin
                    chk("c_post_reset_rd_en", int'(o_rd_en), 0);
                    chk("c_post_reset_rd_sel", int'(o_rd_sel), 0);
                    chk("c_post_reset_in_ready", int'(o_in_ready), 1);
                    chk("c_post_reset_wv", int'(o_window_valid), 0);
                    chk("c_post_reset_intr", int'(o_intr), 0);
                    chk("c_post_reset_wr_en", int'(o_wr_en), 0);
                end
                default: ;
            endcase
            step();
        end
        axi_rst = 1'b0;
        repeat (4) step();

        chk("wr_queue_drained", wr_q.size(), 0);
        chk("rd_queue_drained", rd_q.size(), 0);
        chk("intr_queue_drained", intr_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
